// File: rtl/pc_pkg.sv
// Shared types for the program counter: the resolved per-cycle operation and
// the priority encoder that turns the raw request lines into one operation.
package pc_pkg;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    LOAD,
    CALL,
    RET
  } pc_op_t;

  // ret beats call beats load beats inc; everything else holds.
  function automatic pc_op_t decode_op(input logic load, input logic inc,
                                       input logic call, input logic ret);
    if (ret)       return RET;
    else if (call) return CALL;
    else if (load) return LOAD;
    else if (inc)  return INC;
    else           return HOLD;
  endfunction

endpackage

// File: rtl/inc.sv
// WIDTH-bit incrementer; all-ones wraps silently to zero.
module inc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_value,
  output logic [WIDTH-1:0] out_value
);

  assign out_value = in_value + WIDTH'(1);

endmodule

// File: rtl/lifo_stack.sv
// Register-array LIFO holding return addresses. Pop wins over push, a push
// when full and a pop when empty are both ignored; storage needs no reset.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             do_push, do_pop;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;
  assign depth   = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (do_pop)       depth_d = depth_q - DW'(1);
    else if (do_push) depth_d = depth_q + DW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && depth_q == DW'(i)) mem[i] <= wdata;
    end
  end

  // Top of stack is the entry just below the pointer.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Hack program counter with a hardware return-address stack: hold, inc,
// load, call and ret, plus sticky overflow/underflow flags.
module pc_stack
  import pc_pkg::*;
#(
  parameter int              WIDTH       = 16,
  parameter int              DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int             DW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] load_value,
  input  logic             err_clear,
  output logic [WIDTH-1:0] pc,
  output logic [DW-1:0]    depth,
  output logic             overflow,
  output logic             underflow
);

  pc_op_t           op;
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus1, top;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             full, empty;

  assign op = decode_op(load, inc, call, ret);

  inc #(.WIDTH(WIDTH)) u_inc (
    .in_value  (pc_q),
    .out_value (pc_plus1)
  );

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (op == CALL),
    .pop   (op == RET),
    .wdata (pc_plus1),
    .rdata (top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // A flag-setting event in the same cycle overrides err_clear.
  always_comb begin
    pc_d        = pc_q;
    overflow_d  = overflow_q && !err_clear;
    underflow_d = underflow_q && !err_clear;
    case (op)
      INC:  pc_d = pc_plus1;
      LOAD: pc_d = load_value;
      CALL: begin
        pc_d = load_value;
        if (full) overflow_d = 1'b1;
      end
      RET: begin
        if (empty) underflow_d = 1'b1;
        else       pc_d = top;
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VALUE;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc        = pc_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed and randomized checks of pc_stack against a queue-based model.
module tb_pc_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             load, inc, call, ret, err_clear;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0]    depth;
  logic             overflow, underflow;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stack[$];
  bit               m_ovf, m_unf;

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE('0)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .inc        (inc),
    .call       (call),
    .ret        (ret),
    .load_value (load_value),
    .err_clear  (err_clear),
    .pc         (pc),
    .depth      (depth),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_pc = '0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Behavioural effect of one clock edge, straight from the operation rules.
  task automatic modelStep(input bit l, input bit i, input bit c, input bit r,
                           input logic [WIDTH-1:0] v, input bit ec);
    if (ec) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else                    m_unf = 1'b1;
    end else if (c) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 16'd1);
      else                        m_ovf = 1'b1;
      m_pc = v;
    end else if (l) begin
      m_pc = v;
    end else if (i) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (pc === m_pc) else begin
      failures++;
      $error("[TB] FAIL %s pc observed=%0h expected=%0h", tag, pc, m_pc);
    end
    checks++;
    assert (depth === DW'(m_stack.size())) else begin
      failures++;
      $error("[TB] FAIL %s depth observed=%0d expected=%0d", tag, depth, m_stack.size());
    end
    checks++;
    assert (overflow === m_ovf) else begin
      failures++;
      $error("[TB] FAIL %s overflow observed=%0b expected=%0b", tag, overflow, m_ovf);
    end
    checks++;
    assert (underflow === m_unf) else begin
      failures++;
      $error("[TB] FAIL %s underflow observed=%0b expected=%0b", tag, underflow, m_unf);
    end
  endtask

  task automatic expectPc(input string tag, input logic [WIDTH-1:0] exp);
    checks++;
    assert (pc === exp) else begin
      failures++;
      $error("[TB] FAIL %s pc observed=%0h expected=%0h", tag, pc, exp);
    end
  endtask

  // Drive one cycle of requests, let one edge pass, then compare.
  task automatic applyStimulus(input string tag, input bit l, input bit i,
                               input bit c, input bit r,
                               input logic [WIDTH-1:0] v, input bit ec);
    load = l; inc = i; call = c; ret = r; load_value = v; err_clear = ec;
    modelStep(l, i, c, r, v, ec);
    @(posedge clk);
    #1;
    load = 0; inc = 0; call = 0; ret = 0; err_clear = 0;
    checkOutput(tag);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_release");
  endtask

  initial begin
    logic [31:0] rnd;
    reset = 1'b1;
    load = 0; inc = 0; call = 0; ret = 0; err_clear = 0; load_value = '0;
    modelReset();
    @(posedge clk);
    #1;
    doReset();
    expectPc("reset_value", 16'd0);

    for (int n = 1; n <= 5; n++) begin
      applyStimulus("inc_run", 0, 1, 0, 0, '0, 0);
      expectPc("inc_run_const", WIDTH'(n));
    end

    // Reset lands between edges and must clear pc without a clock.
    inc = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    expectPc("reset_mid_run", 16'd0);
    checkOutput("reset_mid_run_all");
    inc = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus("load_ffff", 1, 0, 0, 0, 16'hFFFF, 0);
    applyStimulus("wrap_inc", 0, 1, 0, 0, '0, 0);
    expectPc("wrap_const", 16'h0000);

    applyStimulus("load_10", 1, 0, 0, 0, 16'd10, 0);
    applyStimulus("call_100", 0, 0, 1, 0, 16'd100, 0);
    applyStimulus("call_inc1", 0, 1, 0, 0, '0, 0);
    applyStimulus("call_inc2", 0, 1, 0, 0, '0, 0);
    expectPc("call_inc_const", 16'd102);
    applyStimulus("ret_11", 0, 0, 0, 1, '0, 0);
    expectPc("ret_const", 16'd11);

    doReset();
    applyStimulus("ovf_call10", 0, 0, 1, 0, 16'd10, 0);
    applyStimulus("ovf_call20", 0, 0, 1, 0, 16'd20, 0);
    applyStimulus("ovf_call30", 0, 0, 1, 0, 16'd30, 0);
    applyStimulus("ovf_ret1", 0, 0, 0, 1, '0, 0);
    expectPc("ovf_ret1_const", 16'd11);
    applyStimulus("ovf_ret2", 0, 0, 0, 1, '0, 0);
    expectPc("ovf_ret2_const", 16'd1);
    applyStimulus("ovf_clear", 0, 0, 0, 0, '0, 1);

    applyStimulus("unf_load7", 1, 0, 0, 0, 16'd7, 0);
    applyStimulus("unf_ret", 0, 0, 0, 1, '0, 0);
    expectPc("unf_hold_const", 16'd7);
    applyStimulus("unf_clear", 0, 0, 0, 0, '0, 1);
    applyStimulus("unf_clear_and_ret", 0, 0, 0, 1, '0, 1);
    applyStimulus("unf_clear2", 0, 0, 0, 0, '0, 1);

    applyStimulus("prio_load54", 1, 0, 0, 0, 16'd54, 0);
    applyStimulus("prio_call", 0, 0, 1, 0, 16'd300, 0);
    applyStimulus("prio_all", 1, 1, 1, 1, 16'd999, 0);
    expectPc("prio_all_const", 16'd55);

    for (int n = 0; n < 128; n++) begin
      rnd = $urandom;
      applyStimulus("random", rnd[0], rnd[1], rnd[2] & rnd[5], rnd[3] & rnd[6],
                    (rnd[9] ? 16'hFFFF : WIDTH'($urandom)), rnd[4] & rnd[7] & rnd[8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
